// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD image geometry and loader state encoding
package lcd_pkg;

    localparam int IMG_DIM    = 8;
    localparam int PIX_W      = 8;
    localparam int PIX_ADDR_W = 6;
    localparam int PIX_CNT    = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    // Linear pixel address for an (row, col) pair inside the IMG_DIM x IMG_DIM image
    function automatic logic [PIX_ADDR_W-1:0] pix_addr(
        input logic [2:0] row,
        input logic [2:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/pixel_buf.sv
// rtl/pixel_buf.sv - DEPTH x DATA_W register file, sync write/clear, async read
module pixel_buf
    import lcd_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int ADDR_W = PIX_ADDR_W,
    parameter int DEPTH  = PIX_CNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-cycle write to rd_addr is seen only after the edge, so readers get the old value
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/irom_image_loader.sv
// rtl/irom_image_loader.sv - copies the 64-pixel image ROM into a local buffer on start
module irom_image_loader
    import lcd_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int ADDR_W = PIX_ADDR_W,
    parameter int DEPTH  = PIX_CNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              IROM_EN,
    output logic [ADDR_W-1:0] IROM_A,
    input  logic [DATA_W-1:0] IROM_Q,
    output logic              busy,
    output logic              done,
    output logic              image_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_t     state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic              img_v, img_v_nx;
    logic              cap_v;
    logic [ADDR_W-1:0] cap_a;
    logic              rom_en;
    logic              busy_c;
    logic              done_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            img_v <= 1'b0;
            cap_v <= 1'b0;
            cap_a <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            img_v <= img_v_nx;
            // ROM returns data one cycle after the address, so delay the write tag to match
            cap_v <= (state == FETCH);
            cap_a <= cnt;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        img_v_nx = img_v;
        rom_en   = 1'b1;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FETCH;
                    cnt_nx   = '0;
                    img_v_nx = 1'b0;
                end
            end
            FETCH: begin
                rom_en = 1'b0;
                busy_c = 1'b1;
                // Counter parks at the last address instead of wrapping
                if (cnt == LAST_ADDR) begin
                    state_nx = WAIT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT: begin
                busy_c   = 1'b1;
                state_nx = DONE;
                img_v_nx = 1'b1;
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign IROM_EN     = rom_en;
    assign IROM_A      = cnt;
    assign busy        = busy_c;
    assign done        = done_c;
    assign image_valid = img_v;

    pixel_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_pixel_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (cap_v),
        .wr_addr (cap_a),
        .wr_data (IROM_Q),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_irom_image_loader.sv
// tb/tb_irom_image_loader.sv - directed self-checking bench for irom_image_loader
module tb_irom_image_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       IROM_EN;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q = 8'h00;
    logic       busy;
    logic       done;
    logic       image_valid;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       inv_mode = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    irom_image_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .IROM_EN     (IROM_EN),
        .IROM_A      (IROM_A),
        .IROM_Q      (IROM_Q),
        .busy        (busy),
        .done        (done),
        .image_valid (image_valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    function automatic logic [7:0] rom_word(input logic [5:0] a, input logic inv);
        return inv ? ~{2'b00, a} : ({2'b00, a} ^ 8'hA5);
    endfunction

    // ROM model: one-cycle read latency, reads only while enable is low
    always @(posedge clk) begin
        if (!IROM_EN) IROM_Q <= rom_word(IROM_A, inv_mode);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic sweep(input string tag, input logic inv, input logic zero);
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a);
            step();
            chk(tag, 32'(rd_data), zero ? 32'd0 : 32'(rom_word(6'(a), inv)));
        end
    endtask

    // Entered at a negedge in an IDLE cycle; leaves at the negedge of C67
    task automatic load_and_check(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_iv_drop"}, 32'(image_valid), 32'd0);
        for (int k = 0; k < 64; k++) begin
            chk({tag, "_fetch"}, 32'({IROM_EN, IROM_A, busy, done}),
                32'({1'b0, 6'(k), 1'b1, 1'b0}));
            step();
        end
        chk({tag, "_wait"}, 32'({IROM_EN, IROM_A, busy, done, image_valid}),
            32'({1'b1, 6'd63, 1'b1, 1'b0, 1'b0}));
        step();
        chk({tag, "_done"}, 32'({IROM_EN, busy, done, image_valid}), 32'({1'b1, 1'b0, 1'b1, 1'b1}));
        step();
        chk({tag, "_after"}, 32'({IROM_EN, busy, done, image_valid}), 32'({1'b1, 1'b0, 1'b0, 1'b1}));
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        rd_addr = 6'd0;
        repeat (3) step();
        reset = 1'b0;
        repeat (10) step();
        chk("idle_outputs", 32'({IROM_EN, IROM_A, busy, done, image_valid}),
            32'({1'b1, 6'd0, 1'b0, 1'b0, 1'b0}));
        sweep("idle_buf_zero", 1'b0, 1'b1);

        load_and_check("load1");
        sweep("load1_buf", 1'b0, 1'b0);
        rd_addr = 6'd0;  step(); chk("buf0_a5", 32'(rd_data), 32'h0000_00A5);
        rd_addr = 6'd63; step(); chk("buf63_9a", 32'(rd_data), 32'h0000_009A);

        // start held high: back-to-back loads separated by one IDLE cycle
        start = 1'b1;
        step();
        chk("hold_c1", 32'({IROM_EN, IROM_A, busy, image_valid}), 32'({1'b0, 6'd0, 1'b1, 1'b0}));
        repeat (29) step();
        chk("hold_c30_no_restart", 32'({IROM_A, busy}), 32'({6'd29, 1'b1}));
        repeat (35) step();
        chk("hold_c65", 32'({IROM_EN, busy, done}), 32'({1'b1, 1'b1, 1'b0}));
        step();
        chk("hold_c66", 32'({busy, done, image_valid}), 32'({1'b0, 1'b1, 1'b1}));
        step();
        chk("hold_c67_idle", 32'({IROM_EN, busy, done, image_valid}), 32'({1'b1, 1'b0, 1'b0, 1'b1}));
        step();
        chk("hold_c68_refetch", 32'({IROM_EN, IROM_A, busy, image_valid}),
            32'({1'b0, 6'd0, 1'b1, 1'b0}));
        repeat (64) step();
        chk("hold2_wait", 32'({IROM_EN, busy, done}), 32'({1'b1, 1'b1, 1'b0}));
        step();
        chk("hold2_done", 32'({busy, done, image_valid}), 32'({1'b0, 1'b1, 1'b1}));
        start = 1'b0;
        step();
        chk("hold2_idle", 32'({busy, done, image_valid}), 32'({1'b0, 1'b0, 1'b1}));
        step();
        chk("hold2_stay_idle", 32'({IROM_EN, busy}), 32'({1'b1, 1'b0}));

        // reset during C30 of a load
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (29) step();
        chk("rst_pre_c30", 32'({IROM_A, busy}), 32'({6'd29, 1'b1}));
        reset = 1'b1;
        step();
        chk("rst_outputs", 32'({IROM_EN, IROM_A, busy, done, image_valid}),
            32'({1'b1, 6'd0, 1'b0, 1'b0, 1'b0}));
        reset = 1'b0;
        sweep("rst_buf_zero", 1'b0, 1'b1);
        load_and_check("reload");
        sweep("reload_buf", 1'b0, 1'b0);

        // new ROM contents: every entry must be overwritten
        inv_mode = 1'b1;
        step();
        load_and_check("inv");
        rd_addr = 6'd5;
        step();
        chk("inv_buf5_fa", 32'(rd_data), 32'h0000_00FA);
        sweep("inv_buf", 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
